// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch front end.
//   - FETCH_XLEN : width of the pc/instr fields held in a queue entry
//   - NOP_INSTR  : instruction word carried by a misaligned-fetch fault entry
//   - fq_entry_t : one instruction-queue entry {pc, instr, fault}
//   - fetch_state_e : fetch FSM states (FAULT is only reachable when the
//                     design is built with FETCH_MISALIGN_CHK_EN)
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int FETCH_XLEN = 32;

   localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
      logic                  fault;
   } fq_entry_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_sync_fifo.sv
// ----------------------------------------------------------------------------
// fetch_sync_fifo
//   Small synchronous FIFO used both as the instruction queue and as the
//   in-flight PC FIFO of the fetch unit.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push_i/din_i: write an entry (accepted when not full, or when full and
//                   popping in the same cycle)
//     pop_i       : remove the head entry (ignored when empty)
//     flush_i     : discard all contents; a push in the same cycle lands as
//                   the single surviving entry
//     dout_o      : head entry (contents undefined-but-stable when empty)
//     count_o, full_o, empty_o : occupancy status
// ----------------------------------------------------------------------------
module fetch_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [AW-1:0]               rptr_q, wptr_q;
   logic [CW-1:0]               count_q;
   logic                        do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rptr_q];

   // a full FIFO still takes a push when the head leaves in the same cycle
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rptr_q <= '0;
         if (push_i) begin
            mem_q[0] <= din_i;
            wptr_q   <= ptr_inc('0);
            count_q  <= CW'(1);
         end else begin
            wptr_q  <= '0;
            count_q <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= din_i;
            wptr_q        <= ptr_inc(wptr_q);
         end
         if (do_pop) rptr_q <= ptr_inc(rptr_q);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// ----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction fetch with a decoupled prefetch queue. Issues in-order,
//   pipelined requests to instruction memory, buffers returned words with
//   their PCs and hands them to decode over valid/ready. A redirect flushes
//   the queue and turns every request still in flight into a drop.
//
//   Ports:
//     clk, rst_n                  : clock, asynchronous active-low reset
//     redirect_valid, redirect_pc : front-end redirect (pulse or held)
//     imem_req, imem_addr         : request to instruction memory
//     imem_gnt                    : request accepted this cycle
//     imem_rvalid, imem_rdata     : in-order response
//     if_valid, if_pc, if_instr,
//     if_fault, if_ready          : decode handshake, head of queue
//
//   Build option FETCH_MISALIGN_CHK_EN: a misaligned redirect target enters
//   FAULT and queues one fault entry instead of silently aligning the PC.
//   Queue entries use fetch_pkg::FETCH_XLEN wide fields; XLEN must not
//   exceed it.
// ----------------------------------------------------------------------------
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0100),
   parameter int              FQ_DEPTH  = 4,
   parameter int              MAX_OUTST = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic            if_fault,
   input  logic            if_ready
);

   localparam int OCW = $clog2(MAX_OUTST+1);
   localparam int QCW = $clog2(FQ_DEPTH+1);
   localparam int SW  = ((OCW > QCW) ? OCW : QCW) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [OCW-1:0]  outst_cnt_q, outst_cnt_d;
   logic [OCW-1:0]  drop_cnt_q, drop_cnt_d;

   logic            req_fire, rsp_keep, rsp_drop, deq, redirect_misaligned;

   fq_entry_t       fq_din, fq_head;
   logic            fq_push, fq_full, fq_empty;
   logic [QCW-1:0]  fq_count;

   logic [XLEN-1:0] pcq_head;
   logic [OCW-1:0]  pcq_count;
   logic            pcq_full, pcq_empty;

`ifdef FETCH_MISALIGN_CHK_EN
   assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign redirect_misaligned = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // Every redirect decides the state: aligned targets resume, misaligned
   // ones (only possible with the check enabled) park the unit in FAULT.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) state_d = redirect_misaligned ? FAULT : RUN;
   end

   // ---------------- FSM: outputs ----------------
   // Credits count in-flight requests against free queue slots, so every
   // response that is kept is guaranteed a slot.
   always_comb begin
      imem_req = 1'b0;
      if (rst_n && (state_q == RUN) && !redirect_valid &&
          (outst_cnt_q < OCW'(MAX_OUTST)) &&
          ((SW'(fq_count) + SW'(outst_cnt_q)) < SW'(FQ_DEPTH)))
         imem_req = 1'b1;
   end

   assign imem_addr = fetch_pc_q;
   assign req_fire  = imem_req && imem_gnt;
   assign rsp_keep  = imem_rvalid && (drop_cnt_q == '0);
   assign rsp_drop  = imem_rvalid && (drop_cnt_q != '0);

   // ---------------- counters and fetch PC ----------------
   always_comb begin
      outst_cnt_d = outst_cnt_q + OCW'(req_fire) - OCW'(imem_rvalid);
      fetch_pc_d  = req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      drop_cnt_d  = drop_cnt_q - OCW'(rsp_drop);
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         // no grant can happen this cycle, so whatever is still out after
         // this cycle's response belongs to the old path
         drop_cnt_d = outst_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q  <= RESET_PC;
         outst_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         outst_cnt_q <= outst_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // ---------------- in-flight PC FIFO ----------------
   fetch_sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTST)
   ) u_pc_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (req_fire),
      .din_i   (fetch_pc_q),
      .pop_i   (rsp_keep),
      .flush_i (redirect_valid),
      .dout_o  (pcq_head),
      .count_o (pcq_count),
      .full_o  (pcq_full),
      .empty_o (pcq_empty)
   );

   // ---------------- instruction queue ----------------
   // A misaligned redirect flushes and deposits its fault entry in the same
   // cycle; any response arriving alongside a redirect is old-path and lost.
   always_comb begin
      fq_din.pc    = FETCH_XLEN'(pcq_head);
      fq_din.instr = FETCH_XLEN'(imem_rdata);
      fq_din.fault = 1'b0;
      fq_push      = rsp_keep;
      if (redirect_valid) begin
         fq_din.pc    = FETCH_XLEN'(redirect_pc);
         fq_din.instr = NOP_INSTR;
         fq_din.fault = 1'b1;
         fq_push      = redirect_misaligned;
      end
   end

   assign deq = if_valid && if_ready;

   fetch_sync_fifo #(
      .WIDTH ($bits(fq_entry_t)),
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fq_push),
      .din_i   (fq_din),
      .pop_i   (deq),
      .flush_i (redirect_valid),
      .dout_o  (fq_head),
      .count_o (fq_count),
      .full_o  (fq_full),
      .empty_o (fq_empty)
   );

   // ---------------- decode interface ----------------
   assign if_valid = !fq_empty && !redirect_valid;
   assign if_pc    = fq_empty ? '0 : XLEN'(fq_head.pc);
   assign if_instr = fq_empty ? '0 : XLEN'(fq_head.instr);
`ifdef FETCH_MISALIGN_CHK_EN
   assign if_fault = fq_empty ? 1'b0 : fq_head.fault;
`else
   assign if_fault = 1'b0;
`endif

   // status bits kept for debug visibility only
   logic status_unused;
   assign status_unused = ^{pcq_count, pcq_full, pcq_empty, fq_full,
                            fq_head.fault, redirect_pc[1:0]};

   // memory must never answer a request that was not made
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rvalid && (outst_cnt_q == '0)));

endmodule
